lut_access_arbiter: RTL and testbench

Round-robin scheduler that shares one activation-function lookup table among several neurons in a layer. Each neuron submits a signed pre-activation value. The block arbitrates between requesters, drives the LUT address, captures the LUT `base` and `next__data` outputs, and linearly interpolates between them. It returns one activation value, tagged with the requester id, per accepted request. It sits between the neuron accumulators of a layer and that layer's LUT instance.

---
 rtl/lut_arb_pkg.sv | 26 ++
 rtl/lut_interp.sv | 28 ++
 rtl/lut_access_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_lut_access_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_arb_pkg.sv
// Shared FSM state type, default widths and the id-width helper for lut_access_arbiter.
package lut_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_INTERP = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_DATA_W = 8;

    // Width of a requester id; never below one bit so a 2-requester build still has a port.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/lut_interp.sv
// Combinational linear interpolation between two adjacent LUT entries:
// result = base + floor((next - base) * frac / 2**FRAC_W).
module lut_interp
    import lut_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] next_val,
    input  logic        [FRAC_W-1:0] frac,
    output logic signed [DATA_W-1:0] result
);

    localparam int PROD_W = DATA_W + FRAC_W + 1;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    assign diff    = $signed({next_val[DATA_W-1], next_val}) - $signed({base[DATA_W-1], base});
    // frac is an unsigned weight; the leading zero keeps the product signed without flipping it
    assign prod    = diff * $signed({1'b0, frac});
    assign shifted = prod >>> FRAC_W;
    // The interpolated point lies between base and next, so dropping the upper bits loses nothing.
    assign result  = DATA_W'(base + shifted);

endmodule

// File: rtl/lut_access_arbiter.sv
// Round-robin arbiter sharing one activation LUT between N_REQ neurons, one tagged result per request.
// Define LUT_ARB_INTERP_EN to add linear interpolation between adjacent LUT entries (latency 3 instead of 2).
module lut_access_arbiter
    import lut_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int IN_W   = ADDR_W + FRAC_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*IN_W-1:0]    req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [ADDR_W-1:0]        lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next,
    output logic                     rsp_valid,
    output logic [clog2(N_REQ)-1:0]  rsp_id,
    output logic signed [DATA_W-1:0] rsp_data,
    input  logic                     rsp_ready
);

    localparam int ID_W = clog2(N_REQ);

    state_t            state;
    state_t            state_nx;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_q;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [N_REQ-1:0]  grant_oh;
    logic [IN_W-1:0]   grant_value;

    // Requester index `offset` positions above `last`, wrapping at N_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] last, input int offset);
        int sum;
        sum = int'(last) + offset;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Round-robin search: the requester just served gets the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_found && req_valid[rr_index(ptr, k)]) begin
                grant_found = 1'b1;
                grant_id    = rr_index(ptr, k);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_found) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign grant_value = req_data[grant_id*IN_W +: IN_W];

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                // The strobe is combinational, so keep it quiet while reset is still held.
                if (grant_found && rst) begin
                    req_ready = grant_oh;
                    state_nx  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
`ifdef LUT_ARB_INTERP_EN
                state_nx = ST_INTERP;
`else
                state_nx = ST_OUTPUT;
`endif
            end
`ifdef LUT_ARB_INTERP_EN
            ST_INTERP: begin
                state_nx = ST_OUTPUT;
            end
`endif
            ST_OUTPUT: begin
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

`ifdef LUT_ARB_INTERP_EN
    logic        [FRAC_W-1:0] frac_q;
    logic signed [DATA_W-1:0] base_q;
    logic signed [DATA_W-1:0] next_q;
    logic signed [DATA_W-1:0] interp_result;

    lut_interp #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_interp (
        .base     (base_q),
        .next_val (next_q),
        .frac     (frac_q),
        .result   (interp_result)
    );
`else
    // Without interpolation the partner entry and the fraction bits have no consumer.
    logic unused_ok;
    assign unused_ok = ^{lut_next, grant_value[FRAC_W-1:0]};
`endif

    // lut_address is loaded at accept time so it is already valid throughout LOOKUP and holds afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= ID_W'(N_REQ - 1);
            gnt_q       <= '0;
            lut_address <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
`ifdef LUT_ARB_INTERP_EN
            frac_q      <= '0;
            base_q      <= '0;
            next_q      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        gnt_q       <= grant_id;
                        lut_address <= grant_value[IN_W-1 -: ADDR_W];
`ifdef LUT_ARB_INTERP_EN
                        frac_q      <= grant_value[FRAC_W-1:0];
`endif
                    end
                end
                ST_LOOKUP: begin
`ifdef LUT_ARB_INTERP_EN
                    base_q <= lut_base;
                    next_q <= lut_next;
`else
                    rsp_data  <= lut_base;
                    rsp_id    <= gnt_q;
                    rsp_valid <= 1'b1;
`endif
                end
`ifdef LUT_ARB_INTERP_EN
                ST_INTERP: begin
                    rsp_data  <= interp_result;
                    rsp_id    <= gnt_q;
                    rsp_valid <= 1'b1;
                end
`endif
                ST_OUTPUT: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= gnt_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Self-checking bench for lut_access_arbiter: table vectors, fairness, backpressure, reset mid-flight, random traffic.
module tb_lut_access_arbiter;

    localparam int N_REQ  = 4;
    localparam int IN_W   = 8;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
`ifdef LUT_ARB_INTERP_EN
    localparam bit INTERP = 1'b1;
    localparam int LAT    = 3;
`else
    localparam bit INTERP = 1'b0;
    localparam int LAT    = 2;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ*IN_W-1:0]    req_data = '0;
    logic [N_REQ-1:0]         req_ready;
    logic [ADDR_W-1:0]        lut_address;
    logic signed [DATA_W-1:0] lut_base;
    logic signed [DATA_W-1:0] lut_next;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic signed [DATA_W-1:0] rsp_data;
    logic                     rsp_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = N_REQ - 1;

    lut_access_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready)
    );

    always #5 clk = ~clk;

    // Behavioural LUT: entry = addr*16, partner = next entry, saturating at the top positive address.
    always_comb begin
        lut_base = {lut_address, 4'h0};
        lut_next = (lut_address == 4'd7) ? lut_base : {lut_address + 4'd1, 4'h0};
    end

    typedef struct {
        int         id;
        logic [7:0] value;
        int         exp_addr;
        int         exp_interp;
        int         exp_flat;
    } vec_t;

    task automatic check(input string name, input logic signed [31:0] actual, input logic signed [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected activation from plain arithmetic on the signed address and fraction.
    function automatic int ref_result(input logic [7:0] v);
        int a, base, nxt, frac, p, q;
        a = int'(v[7:4]);
        if (a >= 8) a = a - 16;
        base = a * 16;
        nxt  = (a == 7) ? base : (a + 1) * 16;
        frac = int'(v[3:0]);
        if (!INTERP) return base;
        p = (nxt - base) * frac;
        q = p / 16;
        if (p < 0 && (p % 16) != 0) q = q - 1;
        return base + q;
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] mask);
        for (int k = 1; k <= N_REQ; k++) begin
            if (mask[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    // One full transaction, called with the DUT idle; hold = cycles of rsp_ready low after rsp_valid.
    task automatic serve(input logic [3:0] mask, input logic [31:0] data, input int hold,
                         output int gid, output logic signed [7:0] got_data);
        int                exp_id;
        int                waited;
        int                lat;
        logic [7:0]        v;
        logic signed [7:0] held_data;
        logic [1:0]        held_id;
        gid       = -1;
        got_data  = 'x;
        req_valid = mask;
        req_data  = data;
        #1;
        exp_id = rr_pick(ptr_m, mask);
        waited = 0;
        while (req_ready == '0 && waited < 8) begin
            cyc();
            waited++;
        end
        check("grant_immediate", waited, 0);
        if (req_ready == '0) return;
        check("grant_onehot", $onehot(req_ready), 1);
        check("grant_id", req_ready, 1 << exp_id);
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gid = i;
        v = data[gid*8 +: 8];
        cyc();
        check("lut_address", lut_address, v[7:4]);
        check("ready_busy", req_ready, 0);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            cyc();
            lat++;
        end
        check("latency", lat, LAT);
        if (!rsp_valid) return;
        check("rsp_id", rsp_id, gid);
        check("rsp_data", rsp_data, ref_result(v));
        got_data  = rsp_data;
        held_data = rsp_data;
        held_id   = rsp_id;
        for (int i = 0; i < hold; i++) begin
            cyc();
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, held_data);
            check("bp_id", rsp_id, held_id);
            check("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        ptr_m = gid;
        check("rsp_cleared", rsp_valid, 0);
        check("next_grant", req_ready, 1 << rr_pick(ptr_m, mask));
    endtask

    initial begin
        vec_t              vecs[4];
        int                gid;
        int                exp_id;
        logic signed [7:0] got;
        int                fair_exp[5];

        vecs[0] = '{0, 8'h25, 2,  37,   32};
        vecs[1] = '{1, 8'h7A, 7,  112,  112};
        vecs[2] = '{2, 8'hF8, 15, -8,   -16};
        vecs[3] = '{3, 8'h83, 8,  -125, -128};
        fair_exp = '{0, 1, 2, 3, 0};

        // Reset state, with all requesters asserting.
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_lut_address", lut_address, 0);
        req_valid = '0;
        repeat (3) cyc();
        rst = 1'b1;
        #1;

        // Table vectors: one requester at a time.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = $urandom;
            d[vecs[i].id*8 +: 8] = vecs[i].value;
            serve(4'(1 << vecs[i].id), d, 0, gid, got);
            check("vec_id", gid, vecs[i].id);
            check("vec_data", got, INTERP ? vecs[i].exp_interp : vecs[i].exp_flat);
        end

        // Fairness: all requesters held high.
        for (int i = 0; i < 5; i++) begin
            serve(4'hF, 32'h83F87A25, 0, gid, got);
            check("fair_order", gid, fair_exp[i]);
        end

        // Backpressure: consumer stalls for 5 cycles.
        serve(4'hF, 32'h83F87A25, 5, gid, got);
        check("bp_grant", gid, 1);

        // Reset during the last processing state before the response.
        req_valid = 4'hF;
        req_data  = 32'h83F87A25;
        #1;
        exp_id = rr_pick(ptr_m, 4'hF);
        check("mid_grant", req_ready, 1 << exp_id);
        cyc();
        if (INTERP) cyc();
        rst = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_id", rsp_id, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_lut_address", lut_address, 0);
        cyc();
        cyc();
        check("mid_rst_no_rsp", rsp_valid, 0);
        rst   = 1'b1;
        ptr_m = N_REQ - 1;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        serve(4'hF, 32'h83F87A25, 0, gid, got);
        check("post_rst_id", gid, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            serve(4'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 2)), gid, got);
        end

        req_valid = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "watchdog");
    end

endmodule
